icc_hazard_controller: RTL
==========================

Name: icc_hazard_controller

Overview:
- Sequences every write of integer condition codes (icc) into the processor status register.
- Tracks in-flight icc-modifying instructions and stalls a conditional branch in decode until its icc source has retired.
- Resolves the branch with the SPARC Bicc condition and annul rule.
- Sits between the pipeline control unit and the PSR register; it owns that register's enable and flag inputs.

Parameters:
- MAX_PEND, 2, maximum number of icc-writing instructions in flight between issue and writeback.
- CNT_W, 2, width of the pending counter; must satisfy 2^CNT_W > MAX_PEND.

Ports:
- clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous active-high reset.
- cc_issue  input  1  an icc-writing instruction leaves decode this cycle; qualified by !stall.
- cc_wb  input  1  an icc-writing instruction retires this cycle.
- wb_flags  input  4  icc at writeback: [3]=Z, [2]=C, [1]=N, [0]=V.
- flush  input  1  squash all in-flight instructions and the decode branch.
- br_valid  input  1  a Bicc is in decode; held high until br_done.
- br_cond  input  4  Bicc cond field; stable while br_valid is high.
- br_annul  input  1  Bicc a-bit; stable while br_valid is high.
- psr_we  output  1  PSR register enable.
- psr_flags  output  4  PSR register flag input.
- icc_q  output  4  shadow copy of the committed icc.
- pend_cnt  output  CNT_W  number of icc writes in flight.
- stall  output  1  hold decode.
- br_done  output  1  branch resolved this cycle (one-cycle pulse).
- br_taken  output  1  branch taken; valid only when br_done=1.
- annul_slot  output  1  annul the delay slot; valid only when br_done=1.
- pend_err  output  1  sticky flag for counter overflow or underflow.

Behaviour:
- Reset (Clr=1, asynchronous):
  - state=IDLE; icc_q=0; pend_cnt=0; pend_err=0.
  - All outputs 0.
  - Clr asserted mid-WAIT or mid-RESOLVE aborts the branch; no br_done is produced.
- PSR write path:
  - psr_we=cc_wb and psr_flags=wb_flags, both combinational.
  - icc_q<=wb_flags at the same edge, so the new icc is visible in icc_q on the next cycle.
- Pending counter, priority highest first:
  - flush clears the counter to 0. A cc_wb in the same cycle still writes the PSR and icc_q.
  - cc_issue and cc_wb together leave the counter unchanged.
  - cc_issue alone increments. If the counter is already MAX_PEND, it holds and pend_err<=1.
  - cc_wb alone decrements. If the counter is already 0, it holds at 0, pend_err<=1, and the PSR write still occurs.
- FSM states are IDLE, WAIT and RESOLVE.
  - IDLE, br_valid=0: stall=0; remain in IDLE.
  - IDLE, br_valid=1: stall=1. Go to RESOLVE if pend_cnt==0, else go to WAIT.
  - WAIT: stall=1. Go to RESOLVE when the registered pend_cnt==0.
  - RESOLVE: stall=0. br_done=1 and br_taken/annul_slot are evaluated from the current icc_q. Go to IDLE.
  - flush in WAIT or RESOLVE returns the FSM to IDLE with br_done=0.
  - A cc_issue from the branch's own cycle is never counted; the controller relies on stall to block it.
- Latency:
  - Branch with no pending writes: br_valid at cycle t, br_done at t+1.
  - Branch with pending writes: br_done one cycle after the edge at which pend_cnt reaches 0.
- Conditions (cond: taken when):
  - 0000 never; 1000 always.
  - 0001 Z; 1001 !Z.
  - 0010 Z|(N^V); 1010 !(Z|(N^V)).
  - 0011 N^V; 1011 !(N^V).
  - 0100 C|Z; 1100 !(C|Z).
  - 0101 C; 1101 !C.
  - 0110 N; 1110 !N.
  - 0111 V; 1111 !V.
- Annul: annul_slot = br_annul & (!br_taken | br_cond==1000).

Test Plan:
- Reset then br_valid=1 with cond=0001 -> stall=1 at t; at t+1 br_done=1, br_taken=0 (Z=0), stall=0.
- cc_issue at t0 and t1 (pend_cnt=2); br_valid with cond=0101 at t2 -> stall held through two cc_wb carrying wb_flags=0100; br_done one cycle after pend_cnt=0 with br_taken=1; psr_we pulses twice.
- cond=1000 with br_annul=1 -> br_taken=1, annul_slot=1; cond=0001 with a=1 and Z=1 -> taken, annul_slot=0; with Z=0 -> annul_slot=1.
- Simultaneous cc_issue and cc_wb at pend_cnt=1 -> pend_cnt stays 1 and icc_q updates; a third cc_issue at pend_cnt=2 -> pend_err=1, pend_cnt=2.
- flush during WAIT with pend_cnt=2 -> pend_cnt=0, FSM in IDLE, no br_done; cc_wb in the flush cycle still gives psr_we=1.
- Clr pulsed mid-WAIT -> immediate (asynchronous) zero of stall, icc_q, pend_cnt and pend_err; no br_done after Clr releases.

Source files
------------

// File: rtl/icc_hazard_controller_if.sv
// Handshake bundle between the pipeline control unit and the icc hazard controller.
// The master is the pipeline side; the slave is the controller, which also drives the PSR enable/flags.
interface icc_hazard_controller_if #(
  parameter int CNT_W = 2
);
  logic             cc_issue;
  logic             cc_wb;
  logic [3:0]       wb_flags;
  logic             flush;
  logic             br_valid;
  logic [3:0]       br_cond;
  logic             br_annul;
  logic             psr_we;
  logic [3:0]       psr_flags;
  logic [3:0]       icc_q;
  logic [CNT_W-1:0] pend_cnt;
  logic             stall;
  logic             br_done;
  logic             br_taken;
  logic             annul_slot;
  logic             pend_err;

  modport master (
    output cc_issue, cc_wb, wb_flags, flush, br_valid, br_cond, br_annul,
    input  psr_we, psr_flags, icc_q, pend_cnt, stall, br_done, br_taken, annul_slot, pend_err
  );

  modport slave (
    input  cc_issue, cc_wb, wb_flags, flush, br_valid, br_cond, br_annul,
    output psr_we, psr_flags, icc_q, pend_cnt, stall, br_done, br_taken, annul_slot, pend_err
  );
endinterface

// File: rtl/icc_hazard_controller.sv
// Sequences icc writes into the PSR and holds a Bicc in decode until its icc source retires.
// Branch resolves one cycle after acceptance when nothing is pending; otherwise one cycle after the count drains.
module icc_hazard_controller #(
  parameter int MAX_PEND = 2,
  parameter int CNT_W    = 2
) (
  input logic                clk,
  input logic                Clr,
  icc_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESOLVE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       icc;
  logic             err;
  logic             stall_i;
  logic             issue;
  logic             resolving;
  logic             taken_i;

  // Bicc: the low three cond bits pick a test, cond[3] inverts it.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v, base;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  assign stall_i   = !Clr && ((state == IDLE && bus.br_valid) || state == WAIT);
  assign issue     = bus.cc_issue && !stall_i;
  assign resolving = !Clr && state == RESOLVE && !bus.flush;
  assign taken_i   = cond_true(bus.br_cond, icc);

  assign bus.stall      = stall_i;
  assign bus.br_done    = resolving;
  assign bus.br_taken   = resolving && taken_i;
  assign bus.annul_slot = resolving && bus.br_annul && (!taken_i || bus.br_cond == 4'b1000);
  assign bus.psr_we     = bus.cc_wb && !Clr;
  assign bus.psr_flags  = Clr ? 4'b0000 : bus.wb_flags;
  assign bus.icc_q      = icc;
  assign bus.pend_cnt   = cnt;
  assign bus.pend_err   = err;

  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.br_valid && !bus.flush)
            state <= (cnt == '0) ? RESOLVE : WAIT;
        end
        WAIT: begin
          if (bus.flush)
            state <= IDLE;
          else if (cnt == '0)
            state <= RESOLVE;
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The retiring write always lands in icc, even under flush or counter underflow.
  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      cnt <= '0;
      icc <= '0;
      err <= 1'b0;
    end else begin
      if (bus.cc_wb)
        icc <= bus.wb_flags;
      if (bus.flush) begin
        cnt <= '0;
      end else if (issue != bus.cc_wb) begin
        if (issue) begin
          if (cnt == MAX_CNT) err <= 1'b1;
          else                cnt <= cnt + ONE;
        end else begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - ONE;
        end
      end
    end
  end

endmodule
